loop_seq_ctrl: RTL and testbench

- Hardware loop sequencer. Runs a bounded "while (count <= limit)" loop: increments a counter once every `gap` clock cycles until the limit is passed.
- Handshake: start/busy/done.
- Used wherever a counter must be stepped at a fixed cadence and then stopped cleanly, e.g. sweep or loop-stimulus engines in the verification and datapath areas.

---
 rtl/loop_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_loop_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: hardware loop sequencer for "while (count <= limit)".
// The counter steps once every `gap` cycles and the loop stops after
// limit+1 steps. Handshake is start/busy/done.
// Optional watchdog: define LOOP_SEQ_WDOG_EN to enable the TIMEOUT cycle limit.
module loop_seq_ctrl #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned GAP_W   = 8,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] limit,
    input  logic [GAP_W-1:0] gap,
    output logic [CNT_W-1:0] count,
    output logic             step,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             step_q, step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick_c;
    logic             last_c;

`ifdef LOOP_SEQ_WDOG_EN
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    logic             wd_hit_c;
`endif

    // A step happens on the edge where the gap counter reaches gap-1;
    // the step is the final one when the pre-increment count equals the limit.
    assign tick_c = (gap_cnt_q == (gap_q - GAP_W'(1)));
    assign last_c = tick_c && (count_q == limit_q);

`ifdef LOOP_SEQ_WDOG_EN
    assign wd_hit_c = (wd_cnt_q == WD_W'(TIMEOUT - 1));
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            gap_q     <= GAP_W'(1);
            gap_cnt_q <= '0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LOOP_SEQ_WDOG_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef LOOP_SEQ_WDOG_EN
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        step_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef LOOP_SEQ_WDOG_EN
        wd_cnt_d  = busy_q ? (wd_cnt_q + WD_W'(1)) : wd_cnt_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // done_q high means the done cycle is still in progress.
                if (start && !abort && !done_q) begin
                    limit_d   = limit;
                    gap_d     = (gap == '0) ? GAP_W'(1) : gap;
                    count_d   = '0;
                    gap_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
`ifdef LOOP_SEQ_WDOG_EN
                    wd_cnt_d  = '0;
`endif
                end
            end

            S_RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef LOOP_SEQ_WDOG_EN
                else if (wd_hit_c && !last_c) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
`endif
                else if (tick_c) begin
                    gap_cnt_d = '0;
                    count_d   = count_q + CNT_W'(1);
                    step_d    = 1'b1;
                    if (last_c) begin
                        state_d = S_FIN;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign step  = step_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef LOOP_SEQ_WDOG_EN
    assign timeout = timeout_q;
`else
    // Watchdog compiled out: TIMEOUT has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Self-checking bench for loop_seq_ctrl. The reference model derives the
// expected outputs for every cycle after start directly from the loop rules:
// steps at multiples of gap, limit+1 steps, done one cycle after the last
// step, and truncation by abort or watchdog.
module tb_loop_seq_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned GAP_W   = 8;
    localparam int unsigned TIMEOUT = 100;
    localparam int          CNT_M   = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] limit;
    logic [GAP_W-1:0] gap;
    logic [CNT_W-1:0] count;
    logic             step;
    logic             busy;
    logic             done;
    logic             timeout;

    int checks;
    int errors;

    loop_seq_ctrl #(
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .limit   (limit),
        .gap     (gap),
        .count   (count),
        .step    (step),
        .busy    (busy),
        .done    (done),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge at which the loop is cut short (abort or watchdog), 0 if it runs out.
    // Abort wins over the watchdog on the same edge; the final step wins over the watchdog.
    function automatic int cut_of(input int total, input int abort_at);
        int k;
        k = 0;
        if (abort_at >= 1 && abort_at <= total) k = abort_at;
`ifdef LOOP_SEQ_WDOG_EN
        if (int'(TIMEOUT) < total && (k == 0 || int'(TIMEOUT) < k)) k = int'(TIMEOUT);
`endif
        return k;
    endfunction

    // Expected {busy, step, done, timeout, count} observed after edge E0+t.
    function automatic logic [7:0] model_at(input int t, input int total, input int g,
                                            input int k, input bit wd);
        int  c;
        logic b, s, d, to;
        if (k != 0 && t >= k) begin
            b  = 1'b0;
            s  = 1'b0;
            d  = 1'b0;
            to = wd && (t == k);
            c  = (k - 1) / g;
        end else begin
            b  = (t <= total);
            s  = (t >= 1) && (t <= total) && (t % g == 0);
            d  = (t == total + 1);
            to = 1'b0;
            c  = ((t < total) ? t : total) / g;
        end
        return {b, s, d, to, 4'(c % CNT_M)};
    endfunction

    // Launch one loop and compare every cycle against the model until it has settled.
    task automatic run_scenario(input string name, input int lim, input int gp,
                                input int abort_at, input bit noise, input bit start_in_done);
        int g, total, k, last;
        bit wd;
        logic [7:0] exp_v, obs_v;
        g     = (gp == 0) ? 1 : gp;
        total = (lim + 1) * g;
        k     = cut_of(total, abort_at);
        wd    = (k != 0) && (k != abort_at);
        last  = (k != 0) ? k + 2 : total + 3;
        @(negedge clk);
        limit = CNT_W'(lim);
        gap   = GAP_W'(gp);
        start = 1'b1;
        abort = 1'b0;
        for (int t = 0; t <= last; t++) begin
            if (t > 0) begin
                @(negedge clk);
                abort = (t == abort_at);
                if (noise) begin
                    limit = CNT_W'($urandom);
                    gap   = GAP_W'($urandom);
                end
                if (noise && t < ((k != 0) ? k : total + 1))
                    start = 1'($urandom_range(0, 1));
                else
                    start = start_in_done && (k == 0) && (t == total + 2);
            end
            @(posedge clk);
            #1;
            exp_v = model_at(t, total, g, k, wd);
            obs_v = {busy, step, done, timeout, count};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s t=%0d lim=%0d gap=%0d {busy,step,done,timeout,count}: got %b required %b",
                         name, t, lim, gp, obs_v, exp_v);
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        limit = '0;
        gap   = '0;
        #12;
        checks++;
        if ({busy, step, done, timeout, count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", {busy, step, done, timeout, count}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        run_scenario("nominal", 10, 10, 0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        run_scenario("wrap", 15, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gap_zero();
        run_scenario("gap_zero", 3, 0, 0, 1'b0, 1'b0);
        run_scenario("gap_one", 3, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        // third step lands at t=12 with gap=4; abort on edge 14 leaves count=3
        run_scenario("abort_run", 10, 4, 14, 1'b1, 1'b0);
        // abort during FIN (t=total+1) must not suppress done
        run_scenario("abort_fin", 2, 3, 10, 1'b0, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        limit = CNT_W'(5);
        gap   = GAP_W'(2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy, step, done, timeout} !== 4'b0000) begin
                errors++;
                $display("FAIL start_abort_idle cyc=%0d {busy,step,done,timeout}: got %b required %b",
                         i, {busy, step, done, timeout}, 4'b0000);
            end
            @(negedge clk);
            start = (i == 0);
            abort = (i == 0);
        end
        run_scenario("after_idle_abort", 1, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int n;
        @(negedge clk);
        limit = CNT_W'(10);
        gap   = GAP_W'(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (count !== CNT_W'(5) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (count !== CNT_W'(5)) begin
            errors++;
            $display("FAIL reset_mid_run_wait: got count %0d required 5 within 60 cycles", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, step, done, timeout, count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_run: got %b required %b", {busy, step, done, timeout, count}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_scenario("after_reset", 4, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int lim, gp, ab, total;
        for (int r = 0; r < 16; r++) begin
            lim   = int'($urandom_range(0, CNT_M - 1));
            gp    = int'($urandom_range(0, 6));
            total = (lim + 1) * ((gp == 0) ? 1 : gp);
            ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, total + 1)) : 0;
            run_scenario("random", lim, gp, ab, 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef LOOP_SEQ_WDOG_EN
    task automatic test_watchdog();
        run_scenario("watchdog", 10, 10, 0, 1'b0, 1'b0);
        run_scenario("watchdog_final", 9, 10, 0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_nominal();
        test_wrap();
        test_gap_zero();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_run();
        test_random();
`ifdef LOOP_SEQ_WDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
